alu_serial_seq: RTL and testbench

//  Bit-serial ALU sequencer for the LegV8 datapath. It drives one ALU1bit slice for WIDTH

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_serial_seq_slice.sv | 32 +++
 rtl/alu_serial_seq.sv | 138 +++++++++++++
 tb/tb_alu_serial_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the LegV8 bit-serial ALU: slice op codes, flag bit
// positions and the sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b1100;
  localparam logic [3:0] OP_OR    = 4'b1101;
  localparam logic [3:0] OP_ADD   = 4'b1110;
  localparam logic [3:0] OP_SUBAB = 4'b1010;
  localparam logic [3:0] OP_SUBBA = 4'b0110;
  localparam logic [3:0] OP_NOR   = 4'b0000;
  localparam logic [3:0] OP_SLT   = 4'b1011;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's-complement "+1" is needed exactly when one operand is inverted.
  function automatic logic carry_in0(input logic [3:0] s);
    return s[3] ^ s[2];
  endfunction

endpackage

// File: rtl/alu_serial_seq_slice.sv
// One-bit LegV8 ALU slice: optional operand inversion, then AND/OR/SUM/PASS
// selected by s[1:0]; set always carries the raw sum bit for SLT.
module ALU1bit (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       less,
  input  logic [3:0] s,
  output logic       f,
  output logic       cout,
  output logic       set
);

  logic ai;
  logic bi;
  logic sum;

  always_comb begin
    ai   = s[3] ? a : ~a;
    bi   = s[2] ? b : ~b;
    sum  = ai ^ bi ^ cin;
    cout = (ai & bi) | (ai & cin) | (bi & cin);
    set  = sum;
    case (s[1:0])
      2'b00:   f = ai & bi;
      2'b01:   f = ai | bi;
      2'b10:   f = sum;
      default: f = less;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: runs one ALU1bit slice LSB-first for WIDTH cycles,
// then presents the assembled result and NZCV flags with a one-cycle done.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [3:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             msb_cin;
  logic             msb_cout;
  logic             msb_set;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             done_q;
  logic             slice_f;
  logic             slice_cout;
  logic             slice_set;
  logic [WIDTH-1:0] res_fin;

  function automatic logic [3:0] nzcv(input logic [WIDTH-1:0] r,
                                      input logic ci, input logic co);
    logic [3:0] fl;
    fl        = '0;
    fl[FLG_N] = r[WIDTH-1];
    fl[FLG_Z] = (r == '0);
    fl[FLG_C] = co;
    fl[FLG_V] = ci ^ co;
    return fl;
  endfunction

  ALU1bit u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .less (1'b0),
    .s    (op_q),
    .f    (slice_f),
    .cout (slice_cout),
    .set  (slice_set)
  );

  // SLT reports only the sign of a-b taken from the MSB sum bit.
  assign res_fin = (op_q[1:0] == 2'b11) ? {{(WIDTH-1){1'b0}}, msb_set} : res_sh;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      op_q     <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      msb_cin  <= 1'b0;
      msb_cout <= 1'b0;
      msb_set  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            op_q  <= op;
            cnt   <= '0;
            carry <= carry_in0(op);
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {slice_f, res_sh[WIDTH-1:1]};
          carry  <= slice_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            msb_cin  <= carry;
            msb_cout <= slice_cout;
            msb_set  <= slice_set;
          end
        end
        ST_DONE: begin
          result_q <= res_fin;
          flags_q  <= nzcv(res_fin, msb_cin, msb_cout);
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state == ST_RUN);
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: directed operations push hand-computed
// expectations; a monitor pops and compares on every done pulse.
module tb_alu_serial_seq;
  import alu_pkg::*;

  localparam int W = 64;

  typedef struct {
    string       nm;
    logic [63:0] res;
    logic [3:0]  flg;
    int          start_cyc;
  } exp_t;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic [3:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [3:0]    flags;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .flags   (flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n) begin
      if (busy && done) chk("busy_done_overlap", 64'(busy & done), 64'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.nm, " result"}, result, e.res);
          chk({e.nm, " flags"}, 64'(flags), 64'(e.flg));
          chk({e.nm, " latency"}, 64'(cyc - e.start_cyc), 64'(W + 1));
        end
        done_cnt++;
      end
    end
  end

  task automatic issue(input string nm, input logic [3:0] o, input logic [63:0] x,
                       input logic [63:0] y, input logic [63:0] er, input logic [3:0] ef,
                       input bit expect_done);
    exp_t e;
    @(negedge clock);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (expect_done) begin
      e.nm        = nm;
      e.res       = er;
      e.flg       = ef;
      e.start_cyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
    op    = 4'($urandom());
    a     = {$urandom(), $urandom()};
    b     = {$urandom(), $urandom()};
    chk({nm, " busy"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string nm);
    int tgt;
    tgt = done_cnt + 1;
    for (int i = 0; i < 200 && done_cnt < tgt; i++) @(posedge clock);
    if (done_cnt < tgt) chk({nm, " timeout"}, 64'(done_cnt), 64'(tgt));
  endtask

  task automatic run(input string nm, input logic [3:0] o, input logic [63:0] x,
                     input logic [63:0] y, input logic [63:0] er, input logic [3:0] ef);
    issue(nm, o, x, y, er, ef, 1'b1);
    wait_done(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    start   = 1'b0;
    op      = '0;
    a       = '0;
    b       = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset flags", 64'(flags), 64'd0);
    reset_n = 1'b1;

    // flags are {N,Z,C,V}
    run("add_5_3",      OP_ADD,   64'd5, 64'd3, 64'd8, 4'b0000);
    run("subab_3_5",    OP_SUBAB, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
    run("subab_7_7",    OP_SUBAB, 64'd7, 64'd7, 64'd0, 4'b0110);
    run("add_ovf",      OP_ADD,   64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
        64'h8000_0000_0000_0000, 4'b1001);
    run("add_wrap",     OP_ADD,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0110);
    run("subba_3_10",   OP_SUBBA, 64'd3, 64'd10, 64'd7, 4'b0010);
    run("slt_m2_1",     OP_SLT,   64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'd1, 4'b0010);
    run("slt_1_m2",     OP_SLT,   64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 4'b0100);
    run("and",          OP_AND,   64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
        64'hF000_F000_F000_F000, 4'b1010);
    run("or",           OP_OR,    64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
        64'hFFF0_FFF0_FFF0_FFF0, 4'b1010);
    run("nor",          OP_NOR,   64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
        64'h000F_000F_000F_000F, 4'b0000);

    // A second start mid-run must be dropped entirely.
    issue("ignore_start", OP_ADD, 64'd100, 64'd23, 64'd123, 4'b0000, 1'b1);
    repeat (10) @(negedge clock);
    start = 1'b1;
    op    = OP_SUBAB;
    a     = 64'd1;
    b     = 64'd1;
    @(negedge clock);
    start = 1'b0;
    wait_done("ignore_start");
    repeat (80) @(negedge clock);
    chk("ignore_start held", result, 64'd123);
    chk("ignore_start one_done", 64'(done_cnt), 64'd12);

    // Asynchronous reset in the middle of a run.
    issue("abort", OP_ADD, 64'd11, 64'd22, 64'd0, 4'b0000, 1'b0);
    repeat (29) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrun reset busy", 64'(busy), 64'd0);
    chk("midrun reset done", 64'(done), 64'd0);
    chk("midrun reset result", result, 64'd0);
    chk("midrun reset flags", 64'(flags), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run("add_after_reset", OP_ADD, 64'd9, 64'd6, 64'd15, 4'b0000);

    repeat (5) @(negedge clock);
    chk("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
